decode_stage: RTL and testbench

RV64I instruction-decode stage: accepts a fetched instruction, drives rs1/rs2 addresses to the register file, and registers decoded control, immediate and operands into the ID/EX pipeline register. Sits between fetch and execute, wrapping the register file read ports. Owns load-use stall insertion, write-back bypass and branch flush. One-cycle latency, valid/ready on both sides.

---
 rtl/decode_stage_pkg.sv | 51 +++++
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage_imm_gen.sv | 16 +
 rtl/decode_stage.sv | 91 +++++++++
 tb/tb_decode_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: widths, opcodes, ALU/immediate encodings and the ID/EX record
package decode_stage_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    // The W variants fill the top five codes so the op still fits in four bits.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS_B, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW
    } alu_op_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] imm;
        logic [ADDR_WIDTH-1:0] rd;
        logic [2:0]            funct3;
        alu_op_e               alu_op;
        logic                  alu_src_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
    } id_ex_t;
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt, input logic word);
        case (funct3)
            3'b000:  return word ? (alt ? ALU_SUBW : ALU_ADDW) : (alt ? ALU_SUB : ALU_ADD);
            3'b001:  return word ? ALU_SLLW : ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return word ? (alt ? ALU_SRAW : ALU_SRLW) : (alt ? ALU_SRA : ALU_SRL);
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, register-file, write-back and ID/EX signals of the decode stage
interface decode_stage_if;
    import decode_stage_pkg::*;
    logic                  if_valid;
    logic                  if_ready;
    logic [31:0]           if_instr;
    logic [DATA_WIDTH-1:0] if_pc;
    logic [ADDR_WIDTH-1:0] rf_rs1;
    logic [ADDR_WIDTH-1:0] rf_rs2;
    logic [DATA_WIDTH-1:0] rf_rdata1;
    logic [DATA_WIDTH-1:0] rf_rdata2;
    logic                  wb_reg_write;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  flush;
    logic                  ex_ready;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_op1;
    logic [DATA_WIDTH-1:0] ex_op2;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [2:0]            ex_funct3;
    logic [3:0]            ex_alu_op;
    logic                  ex_alu_src_imm;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_branch;
    logic                  ex_jump;
    logic                  ex_illegal;
    modport master (
        input  if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2, wb_reg_write, wb_rd, wb_data, flush, ex_ready,
        output if_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_funct3, ex_alu_op,
               ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal
    );
    modport slave (
        output if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2, wb_reg_write, wb_rd, wb_data, flush, ex_ready,
        input  if_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd, ex_funct3, ex_alu_op,
               ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: sign-extended immediate for each RV64I instruction format
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0]           instr_i,
    input  imm_type_e             imm_type_i,
    output logic [DATA_WIDTH-1:0] imm_o
);
    assign imm_o = (imm_type_i == IMM_S) ? {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                   (imm_type_i == IMM_B) ? {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                                            instr_i[30:25], instr_i[11:8], 1'b0} :
                   (imm_type_i == IMM_U) ? {{(DATA_WIDTH-32){instr_i[31]}}, instr_i[31:12], 12'b0} :
                   (imm_type_i == IMM_J) ? {{(DATA_WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                                            instr_i[20], instr_i[30:21], 1'b0} :
                                           {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV64I decode into the ID/EX register with load-use stall,
// write-back bypass and branch flush
module decode_stage
    import decode_stage_pkg::*;
(
    input logic            clk,
    input logic            reset,
    decode_stage_if.master io
);
    id_ex_t                id_ex_q, id_ex_d, dec;
    imm_type_e             imm_type;
    logic [DATA_WIDTH-1:0] imm;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                  uses_rs1, uses_rs2, adv, stall, fire, shift_alt;
    assign opcode    = io.if_instr[6:0];
    assign funct3    = io.if_instr[14:12];
    assign rd        = io.if_instr[11:7];
    assign rs1       = io.if_instr[19:15];
    assign rs2       = io.if_instr[24:20];
    assign shift_alt = io.if_instr[30] && funct3 == 3'b101;
    assign io.rf_rs1 = rs1;
    assign io.rf_rs2 = rs2;
    assign imm_type  = (opcode == OPC_LUI || opcode == OPC_AUIPC) ? IMM_U :
                       (opcode == OPC_JAL)    ? IMM_J :
                       (opcode == OPC_BRANCH) ? IMM_B :
                       (opcode == OPC_STORE)  ? IMM_S : IMM_I;
    decode_stage_imm_gen u_imm_gen (
        .instr_i    (io.if_instr),
        .imm_type_i (imm_type),
        .imm_o      (imm)
    );
    always_comb begin
        dec        = '0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        dec.valid  = 1'b1;
        dec.pc     = io.if_pc;
        dec.op1    = (rs1 == '0) ? '0 : (io.wb_reg_write && io.wb_rd == rs1) ? io.wb_data : io.rf_rdata1;
        dec.op2    = (rs2 == '0) ? '0 : (io.wb_reg_write && io.wb_rd == rs2) ? io.wb_data : io.rf_rdata2;
        dec.imm    = imm;
        dec.rd     = rd;
        dec.funct3 = funct3;
        case (opcode)
            OPC_LUI:       begin dec.alu_op = ALU_PASS_B; dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; end
            OPC_AUIPC:     begin dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; end
            OPC_JAL:       begin dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1; end
            OPC_JALR:      begin dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1; uses_rs1 = 1'b1; end
            OPC_BRANCH:    begin dec.alu_op = ALU_SUB; dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_LOAD:      begin dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1; uses_rs1 = 1'b1; end
            OPC_STORE:     begin dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP_IMM:    begin dec.alu_op = alu_decode(funct3, shift_alt, 1'b0); dec.alu_src_imm = 1'b1;
                                 dec.reg_write = 1'b1; uses_rs1 = 1'b1; end
            OPC_OP:        begin dec.alu_op = alu_decode(funct3, io.if_instr[30], 1'b0); dec.reg_write = 1'b1;
                                 uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP_IMM_32: begin dec.alu_op = alu_decode(funct3, shift_alt, 1'b1); dec.alu_src_imm = 1'b1;
                                 dec.reg_write = 1'b1; uses_rs1 = 1'b1; end
            OPC_OP_32:     begin dec.alu_op = alu_decode(funct3, io.if_instr[30], 1'b1); dec.reg_write = 1'b1;
                                 uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:       dec.illegal = 1'b1;
        endcase
        dec.reg_write = dec.reg_write && rd != '0;
    end
    // A load in ID/EX whose result is needed now forces one bubble; the bubble clears mem_read.
    assign stall = id_ex_q.valid && id_ex_q.mem_read && id_ex_q.rd != '0 &&
                   ((uses_rs1 && rs1 == id_ex_q.rd) || (uses_rs2 && rs2 == id_ex_q.rd));
    assign adv         = !id_ex_q.valid || io.ex_ready;
    assign io.if_ready = !reset && adv && !stall && !io.flush;
    assign fire        = io.if_valid && io.if_ready;
    assign id_ex_d     = io.flush ? '0 : !adv ? id_ex_q : fire ? dec : '0;
    always_ff @(posedge clk) begin
        if (reset) id_ex_q <= '0;
        else id_ex_q <= id_ex_d;
    end
    assign io.ex_valid       = id_ex_q.valid;
    assign io.ex_pc          = id_ex_q.pc;
    assign io.ex_op1         = id_ex_q.op1;
    assign io.ex_op2         = id_ex_q.op2;
    assign io.ex_imm         = id_ex_q.imm;
    assign io.ex_rd          = id_ex_q.rd;
    assign io.ex_funct3      = id_ex_q.funct3;
    assign io.ex_alu_op      = id_ex_q.alu_op;
    assign io.ex_alu_src_imm = id_ex_q.alu_src_imm;
    assign io.ex_reg_write   = id_ex_q.reg_write;
    assign io.ex_mem_read    = id_ex_q.mem_read;
    assign io.ex_mem_write   = id_ex_q.mem_write;
    assign io.ex_branch      = id_ex_q.branch;
    assign io.ex_jump        = id_ex_q.jump;
    assign io.ex_illegal     = id_ex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a cycle model
module tb_decode_stage;
    import decode_stage_pkg::*;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc, op1, op2, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        src_imm, rw, mr, mw, br, jmp, ill;
    } st_t;
    localparam logic [3:0] BASE_OP [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam logic [6:0] OPCS [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                         7'h13, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h00, 7'h0F};
    logic clk, rst;
    int   checks, passed;
    st_t  m;
    logic exp_rdy, obs_rdy;
    logic [4:0] obs_rs1, obs_rs2;
    decode_stage_if bus();
    decode_stage dut (.clk(clk), .reset(rst), .io(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] imm_of(logic [31:0] ins);
        longint n = ins[31] ? -1 : 0;
        longint v;
        case (ins[6:0])
            7'h37, 7'h17: v = n * 64'sd2147483648 + longint'(ins[30:12]) * 4096;
            7'h23:        v = n * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            7'h63:        v = n * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            7'h6F:        v = n * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            default:      v = n * 2048 + longint'(ins[30:20]);
        endcase
        return v;
    endfunction

    function automatic logic [3:0] arith(logic [2:0] f3, logic alt, logic word);
        logic [3:0] r = BASE_OP[f3];
        if (alt && r == ALU_ADD) r = ALU_SUB;
        if (alt && r == ALU_SRL) r = ALU_SRA;
        if (word) r = (r == ALU_ADD) ? ALU_ADDW : (r == ALU_SUB) ? ALU_SUBW : (r == ALU_SLL) ? ALU_SLLW :
                      (r == ALU_SRL) ? ALU_SRLW : (r == ALU_SRA) ? ALU_SRAW : r;
        return r;
    endfunction

    function automatic logic [63:0] operand(logic [4:0] r, logic [63:0] rf);
        if (r == 0) return 64'd0;
        if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
        return rf;
    endfunction

    function automatic st_t decode(logic [31:0] ins);
        st_t d = '0;
        logic [2:0] f3 = ins[14:12];
        d.valid = 1'b1;
        d.pc = bus.if_pc;
        d.rd = ins[11:7];
        d.f3 = f3;
        d.imm = imm_of(ins);
        d.op1 = operand(ins[19:15], bus.rf_rdata1);
        d.op2 = operand(ins[24:20], bus.rf_rdata2);
        case (ins[6:0])
            7'h37:        begin d.alu = ALU_PASS_B; d.src_imm = 1; d.rw = 1; end
            7'h17:        begin d.alu = ALU_ADD; d.src_imm = 1; d.rw = 1; end
            7'h6F, 7'h67: begin d.alu = ALU_ADD; d.src_imm = 1; d.rw = 1; d.jmp = 1; end
            7'h63:        begin d.alu = ALU_SUB; d.br = 1; end
            7'h03:        begin d.alu = ALU_ADD; d.src_imm = 1; d.rw = 1; d.mr = 1; end
            7'h23:        begin d.alu = ALU_ADD; d.src_imm = 1; d.mw = 1; end
            7'h13, 7'h1B: begin d.alu = arith(f3, f3 == 3'd5 && ins[30], ins[3]); d.src_imm = 1; d.rw = 1; end
            7'h33, 7'h3B: begin d.alu = arith(f3, ins[30], ins[3]); d.rw = 1; end
            default:      d.ill = 1;
        endcase
        if (d.rd == 0) d.rw = 0;
        return d;
    endfunction

    function automatic st_t masked(st_t s);
        st_t r = s;
        if (!s.valid) begin
            r.pc = 0; r.op1 = 0; r.op2 = 0; r.imm = 0; r.rd = 0; r.f3 = 0; r.alu = 0;
        end else if (s.ill) begin
            r.imm = 0; r.alu = 0; r.src_imm = 0;
        end
        return r;
    endfunction

    function automatic st_t obs();
        st_t s;
        s.valid = bus.ex_valid; s.pc = bus.ex_pc; s.op1 = bus.ex_op1; s.op2 = bus.ex_op2; s.imm = bus.ex_imm;
        s.rd = bus.ex_rd; s.f3 = bus.ex_funct3; s.alu = bus.ex_alu_op; s.src_imm = bus.ex_alu_src_imm;
        s.rw = bus.ex_reg_write; s.mr = bus.ex_mem_read; s.mw = bus.ex_mem_write; s.br = bus.ex_branch;
        s.jmp = bus.ex_jump; s.ill = bus.ex_illegal;
        return s;
    endfunction

    task automatic drive(input logic ifv, input logic [31:0] ins, input logic exr, input logic fl);
        bus.if_valid = ifv; bus.if_instr = ins; bus.if_pc = {$urandom, $urandom};
        bus.ex_ready = exr; bus.flush = fl; bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0;
        bus.wb_data = {$urandom, $urandom}; bus.rf_rdata1 = {$urandom, $urandom}; bus.rf_rdata2 = {$urandom, $urandom};
    endtask

    task automatic tick();
        st_t nxt;
        logic adv, stall, u1, u2;
        logic [31:0] ins;
        #2;
        ins = bus.if_instr;
        obs_rdy = bus.if_ready; obs_rs1 = bus.rf_rs1; obs_rs2 = bus.rf_rs2;
        u1 = ins[6:0] inside {7'h13, 7'h1B, 7'h33, 7'h3B, 7'h03, 7'h23, 7'h63, 7'h67};
        u2 = ins[6:0] inside {7'h33, 7'h3B, 7'h23, 7'h63};
        adv = !m.valid || bus.ex_ready;
        stall = m.valid && m.mr && m.rd != 0 && ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
        exp_rdy = !rst && adv && !stall && !bus.flush;
        if (rst || bus.flush) nxt = '0;
        else if (!adv) nxt = m;
        else if (bus.if_valid && exp_rdy) nxt = decode(ins);
        else nxt = '0;
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h00700293, 1'b1, 1'b0);
            tick();
            checks++; if (obs_rdy !== 1'b0) $display("FAIL reset_if_ready: got %b want 0", obs_rdy); else passed++;
            checks++; if (obs() !== '0) $display("FAIL reset_ex_zero: got %h want 0", obs()); else passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h00700293, 1'b1, 1'b0);
        tick();
        checks++; if (obs_rdy !== 1'b1) $display("FAIL addi_if_ready: got %b want 1", obs_rdy); else passed++;
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd5 || bus.ex_imm !== 64'd7 || bus.ex_alu_src_imm !== 1'b1 ||
            bus.ex_reg_write !== 1'b1 || bus.ex_op1 !== 64'd0)
            $display("FAIL addi_fields: got v=%b rd=%0d imm=%h si=%b rw=%b op1=%h want 1 5 7 1 1 0",
                     bus.ex_valid, bus.ex_rd, bus.ex_imm, bus.ex_alu_src_imm, bus.ex_reg_write, bus.ex_op1);
        else passed++;
        checks++; if (masked(obs()) !== masked(m)) $display("FAIL addi_model: got %h want %h", obs(), m); else passed++;
    endtask

    task automatic test_imm();
        drive(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL imm_neg1: got %h want all ones", bus.ex_imm); else passed++;
        drive(1'b1, 32'h80000137, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ex_imm !== 64'hFFFF_FFFF_8000_0000) $display("FAIL imm_lui: got %h want ffffffff80000000", bus.ex_imm); else passed++;
        checks++; if (bus.ex_alu_op !== ALU_PASS_B || bus.ex_rd !== 5'd2) $display("FAIL lui_ctl: got alu=%0d rd=%0d want 10 2", bus.ex_alu_op, bus.ex_rd); else passed++;
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0002B303, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd6) $display("FAIL ld_issue: got mr=%b rd=%0d want 1 6", bus.ex_mem_read, bus.ex_rd); else passed++;
        drive(1'b1, 32'h006303B3, 1'b1, 1'b0);
        tick();
        checks++; if (obs_rdy !== 1'b0) $display("FAIL load_use_ready: got %b want 0", obs_rdy); else passed++;
        checks++; if (bus.ex_valid !== 1'b0) $display("FAIL load_use_bubble: got %b want 0", bus.ex_valid); else passed++;
        drive(1'b1, 32'h006303B3, 1'b1, 1'b0);
        tick();
        checks++; if (obs_rdy !== 1'b1) $display("FAIL after_stall_ready: got %b want 1", obs_rdy); else passed++;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd7) $display("FAIL add_issue: got v=%b rd=%0d want 1 7", bus.ex_valid, bus.ex_rd); else passed++;
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h006303B3, 1'b1, 1'b0);
        bus.rf_rdata1 = 64'd0; bus.rf_rdata2 = 64'd0;
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 64'h1234;
        tick();
        checks++; if (bus.ex_op1 !== 64'h1234 || bus.ex_op2 !== 64'h1234) $display("FAIL bypass_ops: got %h %h want 1234 1234", bus.ex_op1, bus.ex_op2); else passed++;
        drive(1'b1, 32'h000003B3, 1'b1, 1'b0);
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'hFF;
        tick();
        checks++; if (bus.ex_op1 !== 64'd0 || bus.ex_op2 !== 64'd0) $display("FAIL x0_ops: got %h %h want 0 0", bus.ex_op1, bus.ex_op2); else passed++;
        checks++; if (masked(obs()) !== masked(m)) $display("FAIL bypass_model: got %h want %h", obs(), m); else passed++;
    endtask

    task automatic test_hold_flush();
        drive(1'b1, 32'h00700293, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h006303B3, 1'b0, 1'b0);
            tick();
            checks++; if (obs_rdy !== 1'b0) $display("FAIL hold_ready %0d: got %b want 0", i, obs_rdy); else passed++;
            checks++;
            if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd5 || bus.ex_imm !== 64'd7)
                $display("FAIL hold_fields %0d: got v=%b rd=%0d imm=%h want 1 5 7", i, bus.ex_valid, bus.ex_rd, bus.ex_imm);
            else passed++;
            checks++; if (obs() !== m) $display("FAIL hold_model %0d: got %h want %h", i, obs(), m); else passed++;
        end
        drive(1'b1, 32'h006303B3, 1'b0, 1'b1);
        tick();
        checks++; if (obs_rdy !== 1'b0) $display("FAIL flush_ready: got %b want 0", obs_rdy); else passed++;
        checks++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_kill: got %b want 0", bus.ex_valid); else passed++;
        drive(1'b0, 32'h006303B3, 1'b1, 1'b0);
        tick();
        checks++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_dropped: got %b want 0", bus.ex_valid); else passed++;
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h0000007F, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_illegal !== 1'b1 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.ex_mem_read !== 1'b0)
            $display("FAIL illegal: got v=%b ill=%b rw=%b mw=%b mr=%b want 1 1 0 0 0",
                     bus.ex_valid, bus.ex_illegal, bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_read);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[6:0] = OPCS[$urandom_range(0, 13)];
            ins[11:7] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 4) != 0, ins, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            bus.wb_reg_write = 1'($urandom_range(0, 1));
            bus.wb_rd = 5'($urandom_range(0, 3));
            tick();
            checks++; if (obs_rdy !== exp_rdy) $display("FAIL rand_ready %0d: got %b want %b", i, obs_rdy, exp_rdy); else passed++;
            checks++;
            if (obs_rs1 !== ins[19:15] || obs_rs2 !== ins[24:20])
                $display("FAIL rand_rs %0d: got %0d %0d want %0d %0d", i, obs_rs1, obs_rs2, ins[19:15], ins[24:20]);
            else passed++;
            checks++; if (masked(obs()) !== masked(m)) $display("FAIL rand_state %0d: got %h want %h", i, obs(), m); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0002B303, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 32'h00700293, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        checks++; if (obs_rdy !== 1'b0) $display("FAIL midreset_ready: got %b want 0", obs_rdy); else passed++;
        checks++; if (obs() !== '0) $display("FAIL midreset_zero: got %h want 0", obs()); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        m = '0;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        test_reset();
        test_addi();
        test_imm();
        test_load_use();
        test_bypass();
        test_hold_flush();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
